// File: rtl/irq_entry_sequencer.sv
// Interrupt entry/return sequencer for the pipelined CPU: captures EPC, drains the
// pipe, redirects fetch to the handler, and on eret redirects back to EPC.
module irq_entry_sequencer #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_0004,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        interupt,
  input  logic        int_enable,
  input  logic        eret,
  input  logic        id_valid,
  input  logic [31:0] id_pc,
  output logic        stall_if,
  output logic        flush_id,
  output logic        pc_redirect,
  output logic [31:0] redirect_pc,
  output logic [31:0] epc,
  output logic        in_handler,
  output logic        int_ack
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_ENTER,
    ST_HANDLER,
    ST_RETURN
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(DRAIN_CYCLES - 1);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_epc;
  logic        r_stall_if;
  logic        r_flush_id;
  logic        r_pc_redirect;
  logic [31:0] r_redirect_pc;
  logic        r_in_handler;
  logic        r_int_ack;

  state_t      w_next_state;
  logic [3:0]  w_next_cnt;
  logic [31:0] w_next_epc;

  // NOTE: every always_comb output gets a default first so no path leaves a latch.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_next_epc   = r_epc;
    unique case (r_state)
      ST_IDLE: begin
        // Only a real instruction may become the return point; eret is meaningless here.
        if (interupt && int_enable && id_valid) begin
          w_next_state = ST_DRAIN;
          w_next_cnt   = CNT_INIT;
          w_next_epc   = id_pc;
        end
      end
      ST_DRAIN: begin
        if (r_cnt == 4'd0) begin
          w_next_state = ST_ENTER;
        end else begin
          w_next_cnt = r_cnt - 4'd1;
        end
      end
      ST_ENTER: begin
        w_next_state = ST_HANDLER;
      end
      ST_HANDLER: begin
        if (eret && id_valid) begin
          w_next_state = ST_RETURN;
        end
      end
      ST_RETURN: begin
        // Always pass through IDLE so the instruction at EPC is fetched before re-entry.
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so they are glitch-free
  // and line up with the state they describe.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_cnt         <= 4'd0;
      r_epc         <= 32'd0;
      r_stall_if    <= 1'b0;
      r_flush_id    <= 1'b0;
      r_pc_redirect <= 1'b0;
      r_redirect_pc <= 32'd0;
      r_in_handler  <= 1'b0;
      r_int_ack     <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_cnt         <= w_next_cnt;
      r_epc         <= w_next_epc;
      r_stall_if    <= (w_next_state == ST_DRAIN);
      r_flush_id    <= (w_next_state == ST_DRAIN) || (w_next_state == ST_ENTER) ||
                       (w_next_state == ST_RETURN);
      r_pc_redirect <= (w_next_state == ST_ENTER) || (w_next_state == ST_RETURN);
      r_in_handler  <= (w_next_state == ST_HANDLER) || (w_next_state == ST_RETURN);
      r_int_ack     <= (w_next_state == ST_ENTER);
      if (w_next_state == ST_ENTER) begin
        r_redirect_pc <= HANDLER_ADDR;
      end else if (w_next_state == ST_RETURN) begin
        r_redirect_pc <= w_next_epc;
      end else begin
        r_redirect_pc <= 32'd0;
      end
    end
  end

  assign stall_if    = r_stall_if;
  assign flush_id    = r_flush_id;
  assign pc_redirect = r_pc_redirect;
  assign redirect_pc = r_redirect_pc;
  assign epc         = r_epc;
  assign in_handler  = r_in_handler;
  assign int_ack     = r_int_ack;

endmodule

// File: tb/tb_irq_entry_sequencer.sv
// Directed bench for irq_entry_sequencer: reset, masking, entry timing, nesting,
// return with pending request, reset mid-drain, and simultaneous interupt/eret.
module tb_irq_entry_sequencer;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        interupt;
  logic        int_enable;
  logic        eret;
  logic        id_valid;
  logic [31:0] id_pc;
  logic        stall_if;
  logic        flush_id;
  logic        pc_redirect;
  logic [31:0] redirect_pc;
  logic [31:0] epc;
  logic        in_handler;
  logic        int_ack;

  int n_checks = 0;
  int n_pass   = 0;

  irq_entry_sequencer #(
    .HANDLER_ADDR(32'h0000_0004),
    .DRAIN_CYCLES(3)
  ) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .interupt   (interupt),
    .int_enable (int_enable),
    .eret       (eret),
    .id_valid   (id_valid),
    .id_pc      (id_pc),
    .stall_if   (stall_if),
    .flush_id   (flush_id),
    .pc_redirect(pc_redirect),
    .redirect_pc(redirect_pc),
    .epc        (epc),
    .in_handler (in_handler),
    .int_ack    (int_ack)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // Inputs change after the falling edge; outputs are checked after the next falling edge.
  task automatic step();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, observed, expected);
  endtask

  task automatic check_outs(input string tag, input logic s, input logic f, input logic r,
                            input logic [31:0] rpc, input logic [31:0] e, input logic ih,
                            input logic a);
    check({tag, ".stall_if"},    32'(stall_if),    32'(s));
    check({tag, ".flush_id"},    32'(flush_id),    32'(f));
    check({tag, ".pc_redirect"}, 32'(pc_redirect), 32'(r));
    check({tag, ".redirect_pc"}, redirect_pc,      rpc);
    check({tag, ".epc"},         epc,              e);
    check({tag, ".in_handler"},  32'(in_handler),  32'(ih));
    check({tag, ".int_ack"},     32'(int_ack),     32'(a));
  endtask

  initial begin
    reset = 1'b0; interupt = 1'b1; int_enable = 1'b1; eret = 1'b0;
    id_valid = 1'b1; id_pc = 32'h0000_0099;
    @(negedge clk_in);

    // Reset held with a pending request.
    for (int i = 0; i < 3; i++) begin
      step();
      check_outs("reset_hold", 0, 0, 0, 32'h0, 32'h0, 0, 0);
    end

    // Masked by int_enable for 10 cycles.
    reset = 1'b1; int_enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check_outs("mask_ie", 0, 0, 0, 32'h0, 32'h0, 0, 0);
    end

    // Basic entry: request sampled at edge N.
    int_enable = 1'b1; id_pc = 32'h0000_0040;
    step();
    interupt = 1'b0; id_pc = 32'h0000_00AA;
    check_outs("drain1", 1, 1, 0, 32'h0, 32'h40, 0, 0);
    step();
    check_outs("drain2", 1, 1, 0, 32'h0, 32'h40, 0, 0);
    step();
    check_outs("drain3", 1, 1, 0, 32'h0, 32'h40, 0, 0);
    step();
    check_outs("enter", 0, 1, 1, 32'h4, 32'h40, 0, 1);
    step();
    check_outs("handler", 0, 0, 0, 32'h0, 32'h40, 1, 0);

    // Nested request while in handler is ignored.
    interupt = 1'b1; id_pc = 32'h0000_00BB;
    for (int i = 0; i < 5; i++) begin
      step();
      check_outs("nested", 0, 0, 0, 32'h0, 32'h40, 1, 0);
    end

    // eret with interupt still high: eret wins, then re-entry from IDLE.
    eret = 1'b1; id_pc = 32'h0000_0080;
    step();
    eret = 1'b0;
    check_outs("return", 0, 1, 1, 32'h40, 32'h40, 1, 0);
    step();
    check_outs("post_return_idle", 0, 0, 0, 32'h0, 32'h40, 0, 0);
    step();
    interupt = 1'b0;
    check_outs("reentry_drain1", 1, 1, 0, 32'h0, 32'h80, 0, 0);
    step();
    check_outs("reentry_drain2", 1, 1, 0, 32'h0, 32'h80, 0, 0);

    // Reset during the second drain cycle.
    reset = 1'b0;
    step();
    check_outs("reset_mid_drain", 0, 0, 0, 32'h0, 32'h0, 0, 0);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_outs("after_reset_idle", 0, 0, 0, 32'h0, 32'h0, 0, 0);
    end

    // Entry waits for a valid instruction in ID.
    interupt = 1'b1; id_valid = 1'b0; id_pc = 32'h0000_0011;
    for (int i = 0; i < 3; i++) begin
      step();
      check_outs("wait_valid", 0, 0, 0, 32'h0, 32'h0, 0, 0);
    end
    id_valid = 1'b1; id_pc = 32'h0000_0050;
    step();
    interupt = 1'b0;
    check_outs("valid_drain1", 1, 1, 0, 32'h0, 32'h50, 0, 0);
    step();
    step();
    check_outs("valid_drain3", 1, 1, 0, 32'h0, 32'h50, 0, 0);
    step();
    check_outs("valid_enter", 0, 1, 1, 32'h4, 32'h50, 0, 1);
    step();
    check_outs("valid_handler", 0, 0, 0, 32'h0, 32'h50, 1, 0);

    // eret needs a valid ID instruction.
    eret = 1'b1; id_valid = 1'b0;
    step();
    check_outs("eret_bubble", 0, 0, 0, 32'h0, 32'h50, 1, 0);
    id_valid = 1'b1;
    step();
    eret = 1'b0;
    check_outs("return2", 0, 1, 1, 32'h50, 32'h50, 1, 0);
    step();
    check_outs("idle2", 0, 0, 0, 32'h0, 32'h50, 0, 0);

    // Simultaneous interupt and eret in IDLE: interrupt taken.
    interupt = 1'b1; eret = 1'b1; id_pc = 32'h0000_0060;
    step();
    interupt = 1'b0; eret = 1'b0;
    check_outs("idle_int_eret", 1, 1, 0, 32'h0, 32'h60, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
